// File: rtl/sad_row_accumulator_pkg.sv
// sad_pkg: widths and helpers shared across the SAD datapath (compressor tree, accumulator, compare stage)
package sad_pkg;
   localparam int SAD_IN_W = 11;
   localparam int SAD_ROWS = 8;
   function automatic int sad_acc_w(input int in_w, input int rows);
      return in_w + 1 + $clog2(rows);
   endfunction
   localparam int SAD_ACC_W = sad_acc_w(SAD_IN_W, SAD_ROWS);
   typedef enum logic {EMPTY, FULL} out_state_t;
endpackage

// File: rtl/sad_row_accumulator_cpa.sv
// sad_cpa: IN_W-bit carry-propagate adder resolving a sum/carry pair into IN_W+1 bits
module sad_cpa #(
   parameter int IN_W = 11
) (
   input  logic [IN_W-1:0] a,
   input  logic [IN_W-1:0] b,
   output logic [IN_W:0]   s
);
   assign s = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/sad_row_accumulator.sv
// sad_row_accumulator: resolves compressor rows and accumulates ROWS of them into a block SAD.
// Define SAD_CPA_PIPE_EN to register the CPA result before the accumulator (2-cycle latency).
module sad_row_accumulator
   import sad_pkg::*;
#(
   parameter int IN_W = SAD_IN_W,
   parameter int ROWS = SAD_ROWS,
   localparam int ACC_W = sad_acc_w(IN_W, ROWS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_sum,
   input  logic [IN_W-1:0]  in_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sad
);
   localparam int CNT_W = $clog2(ROWS);
   logic [IN_W:0] rv, a_rv;
   logic [CNT_W-1:0] row_cnt;
   logic [ACC_W-1:0] acc;
   logic last_in, in_fire, a_valid, a_last, a_fire, stall;
   out_state_t state, state_nx;
   sad_cpa #(.IN_W(IN_W)) u_cpa (.a(in_sum), .b(in_carry), .s(rv));
   assign last_in = row_cnt == CNT_W'(ROWS - 1);
`ifdef SAD_CPA_PIPE_EN
   logic p_valid, p_last;
   logic [IN_W:0] p_rv;
   assign a_valid = p_valid;
   assign a_rv = p_rv;
   assign a_last = p_last;
   assign stall = p_valid && p_last && out_valid && !out_ready;
   always_ff @(posedge clk)
      if (rst) begin
         p_valid <= 1'b0;
         p_last <= 1'b0;
         p_rv <= '0;
      end else if (!stall) begin
         p_valid <= in_fire;
         p_last <= last_in;
         p_rv <= rv;
      end
`else
   assign a_valid = in_valid;
   assign a_rv = rv;
   assign a_last = last_in;
   // only the closing row of a block must wait for the pending SAD to drain
   assign stall = out_valid && !out_ready && last_in;
`endif
   assign in_ready = !stall;
   assign in_fire = in_valid && in_ready;
   assign a_fire = a_valid && !stall;
   assign out_valid = state == FULL;
   always_ff @(posedge clk)
      if (rst) row_cnt <= '0;
      else if (in_fire) row_cnt <= last_in ? '0 : row_cnt + 1'b1;
   always_ff @(posedge clk)
      if (rst) begin
         acc <= '0;
         out_sad <= '0;
      end else if (a_fire) begin
         acc <= a_last ? '0 : acc + ACC_W'(a_rv);
         if (a_last) out_sad <= acc + ACC_W'(a_rv);
      end
   always_ff @(posedge clk)
      if (rst) state <= EMPTY;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      state_nx = (a_fire && a_last) ? FULL : (out_ready ? EMPTY : state);
   end
endmodule

// File: tb/tb_sad_row_accumulator.sv
// tb_sad_row_accumulator: directed and scoreboarded checks of the SAD row accumulator
module tb_sad_row_accumulator;
   localparam int IN_W = 11;
   localparam int ACC_W = 15;
`ifdef SAD_CPA_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   logic clk = 1'b0;
   logic rst, in_valid, in_ready, out_valid, out_ready;
   logic [IN_W-1:0] in_sum, in_carry;
   logic [ACC_W-1:0] out_sad;
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;
   sad_row_accumulator dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_sum(in_sum), .in_carry(in_carry), .out_valid(out_valid),
      .out_ready(out_ready), .out_sad(out_sad)
   );
   task automatic drive_row(input int s, input int c, output bit ok);
      in_valid = 1'b1;
      in_sum = IN_W'(s);
      in_carry = IN_W'(c);
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
         #1;
         if (in_ready) ok = 1'b1;
         @(negedge clk);
      end
   endtask
   task automatic send_block(input int s, input int c, output int n);
      bit ok;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         drive_row(s, c, ok);
         n += int'(ok);
      end
   endtask
   task automatic wait_out(output int k);
      in_valid = 1'b0;
      k = 0;
      for (int t = 1; t <= 10 && k == 0; t++) begin
         #1;
         if (out_valid) k = t;
         else @(negedge clk);
      end
   endtask
   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      in_sum = '0;
      in_carry = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask
   task automatic test_reset();
      do_reset();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      total++; if (out_sad !== '0) begin bad++; $display("FAIL reset_out_sad: got %0d want 0", out_sad); end
   endtask
   task automatic test_basic();
      int n, k;
      out_ready = 1'b1;
      send_block(100, 20, n);
      wait_out(k);
      total++; if (n != 8) begin bad++; $display("FAIL basic_rows: got %0d want 8", n); end
      total++; if (k != LAT) begin bad++; $display("FAIL basic_latency: got %0d want %0d", k, LAT); end
      total++; if (out_sad !== 15'd960) begin bad++; $display("FAIL basic_sad: got %0d want 960", out_sad); end
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse: got %b want 0", out_valid); end
   endtask
   task automatic test_max();
      int n, k;
      out_ready = 1'b1;
      send_block(2047, 2047, n);
      wait_out(k);
      total++; if (k != LAT) begin bad++; $display("FAIL max_latency: got %0d want %0d", k, LAT); end
      total++; if (out_sad !== 15'd32752) begin bad++; $display("FAIL max_sad: got %0d want 32752", out_sad); end
      @(negedge clk);
   endtask
   task automatic test_backpressure();
      int n, k;
      bit ok;
      out_ready = 1'b0;
      send_block(10, 5, n);
      wait_out(k);
      total++; if (out_sad !== 15'd120 || k != LAT) begin bad++; $display("FAIL bp_first: got %0d lat %0d want 120 lat %0d", out_sad, k, LAT); end
      n = 0;
      for (int i = 0; i < 7; i++) begin
         drive_row(20, 10, ok);
         n += int'(ok);
      end
      total++; if (n != 7) begin bad++; $display("FAIL bp_seven_rows: got %0d want 7", n); end
`ifdef SAD_CPA_PIPE_EN
      drive_row(20, 10, ok);
      in_valid = 1'b0;
      #1;
`else
      in_valid = 1'b1;
      in_sum = 11'd20;
      in_carry = 11'd10;
      #1;
`endif
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_last_stall: got in_ready %b want 0", in_ready); end
      repeat (3) @(negedge clk);
      #1;
      total++; if (out_sad !== 15'd120 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold: got %0d valid %b want 120 valid 1", out_sad, out_valid); end
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got in_ready %b want 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (out_sad !== 15'd240 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_second: got %0d valid %b want 240 valid 1", out_sad, out_valid); end
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", out_valid); end
   endtask
   task automatic test_rst_mid();
      int n, k;
      bit ok;
      out_ready = 1'b0;
      send_block(1, 1, n);
      wait_out(k);
      for (int i = 0; i < 5; i++) drive_row(50, 0, ok);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if (out_valid !== 1'b0 || out_sad !== '0) begin bad++; $display("FAIL rstmid_drop: got valid %b sad %0d want 0 0", out_valid, out_sad); end
      out_ready = 1'b1;
      send_block(1, 0, n);
      wait_out(k);
      total++; if (out_sad !== 15'd8 || k != LAT) begin bad++; $display("FAIL rstmid_sad: got %0d lat %0d want 8 lat %0d", out_sad, k, LAT); end
      @(negedge clk);
   endtask
   task automatic test_back_to_back();
      int stalls, ng;
      logic [ACC_W-1:0] got [2];
      int when [2];
      stalls = 0;
      ng = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 16 + LAT + 3; c++) begin
         in_valid = c < 16;
         in_sum = IN_W'(c + 1);
         in_carry = IN_W'(c);
         #1;
         if (c < 16 && !in_ready) stalls++;
         if (out_valid) begin
            if (ng < 2) begin got[ng] = out_sad; when[ng] = c; end
            ng++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      total++; if (stalls != 0) begin bad++; $display("FAIL b2b_stalls: got %0d want 0", stalls); end
      total++; if (ng != 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", ng); end
      total++; if (got[0] !== 15'd64 || got[1] !== 15'd192) begin bad++; $display("FAIL b2b_sums: got %0d %0d want 64 192", got[0], got[1]); end
      total++; if (when[0] != 7 + LAT || when[1] - when[0] != 8) begin bad++; $display("FAIL b2b_timing: got %0d gap %0d want %0d gap 8", when[0], when[1] - when[0], 7 + LAT); end
   endtask
   task automatic test_random();
      logic [ACC_W-1:0] exp_q [$];
      int sent, got, blk;
      sent = 0;
      got = 0;
      blk = 0;
      do_reset();
      for (int cyc = 0; cyc < 3000 && !(got == 3 && sent == 24); cyc++) begin
         out_ready = 1'($urandom_range(0, 1));
         in_valid = sent < 24 ? 1'($urandom_range(0, 1)) : 1'b0;
         in_sum = IN_W'($urandom_range(0, 2047));
         in_carry = IN_W'($urandom_range(0, 2047));
         #1;
         if (out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL rand_extra: got %0d want none", out_sad); end
            else begin
               if (out_sad !== exp_q[0]) begin bad++; $display("FAIL rand_sad: got %0d want %0d", out_sad, exp_q[0]); end
               void'(exp_q.pop_front());
            end
            got++;
         end
         if (in_valid && in_ready) begin
            blk += int'(in_sum) + int'(in_carry);
            sent++;
            if (sent % 8 == 0) begin
               exp_q.push_back(ACC_W'(blk));
               blk = 0;
            end
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      total++; if (got != 3 || sent != 24 || exp_q.size() != 0) begin bad++; $display("FAIL rand_count: got %0d blocks %0d rows left %0d want 3 24 0", got, sent, exp_q.size()); end
   endtask
   initial begin
      test_reset();
      test_basic();
      test_max();
      test_backpressure();
      test_rst_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
